// File: rtl/multiprecision_add_seq.sv
// Sequential wide adder: feeds one SEG_WIDTH slice per cycle, LSB first, through a single cla_adder.
// Optional subtract mode (Sub_i port) is enabled by defining MULTIPRECISION_ADD_SUB_EN.

module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             cy;

    always_comb begin
        gen   = a_i & b_i;
        prop  = a_i ^ b_i;
        cy    = c_i;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = prop[i] ^ cy;
            cy       = gen[i] | (prop[i] & cy);
        end
        c_o = cy;
    end
endmodule

module multiprecision_add_seq #(
    parameter int SEG_WIDTH = 32,
    parameter int NUM_SEGS  = 4
) (
    input  logic                          Clk_i,
    input  logic                          Rst_i,
    input  logic                          Start_i,
    input  logic [SEG_WIDTH*NUM_SEGS-1:0] Number1_i,
    input  logic [SEG_WIDTH*NUM_SEGS-1:0] Number2_i,
    input  logic                          Carry_i,
`ifdef MULTIPRECISION_ADD_SUB_EN
    input  logic                          Sub_i,
`endif
    output logic [SEG_WIDTH*NUM_SEGS-1:0] Result_o,
    output logic                          Carry_o,
    output logic                          Overflow_o,
    output logic                          Busy_o,
    output logic                          Done_o
);
    localparam int W     = SEG_WIDTH * NUM_SEGS;
    localparam int CNT_W = (NUM_SEGS > 2) ? $clog2(NUM_SEGS) : 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             ovf_q, ovf_d;

    logic [SEG_WIDTH-1:0] seg_a;
    logic [SEG_WIDTH-1:0] seg_b;
    logic [SEG_WIDTH-1:0] seg_sum;
    logic                 seg_cout;
    logic                 accept;

    assign seg_a = a_q[int'(cnt_q)*SEG_WIDTH +: SEG_WIDTH];
    assign seg_b = b_q[int'(cnt_q)*SEG_WIDTH +: SEG_WIDTH];

    cla_adder #(.WIDTH(SEG_WIDTH)) u_cla (
        .a_i   (seg_a),
        .b_i   (seg_b),
        .c_i   (carry_q),
        .sum_o (seg_sum),
        .c_o   (seg_cout)
    );

    assign accept = Start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;

        if (accept) begin
            // Subtraction is A + ~B + 1, so only B and the initial carry change
            a_d = Number1_i;
`ifdef MULTIPRECISION_ADD_SUB_EN
            b_d     = Sub_i ? ~Number2_i : Number2_i;
            carry_d = Sub_i ? 1'b1 : Carry_i;
`else
            b_d     = Number2_i;
            carry_d = Carry_i;
`endif
            result_d    = '0;
            carry_out_d = 1'b0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            state_d     = RUN;
        end else if (state_q == RUN) begin
            result_d[int'(cnt_q)*SEG_WIDTH +: SEG_WIDTH] = seg_sum;
            carry_d = seg_cout;
            if (cnt_q == LAST_SEG) begin
                carry_out_d = seg_cout;
                ovf_d       = (a_q[W-1] == b_q[W-1]) && (seg_sum[SEG_WIDTH-1] != a_q[W-1]);
                state_d     = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk_i) begin
        a_q <= a_d;
        b_q <= b_d;
        if (Rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Result_o   = result_q;
    assign Carry_o    = carry_out_q;
    assign Overflow_o = ovf_q;
    assign Busy_o     = (state_q == RUN);
    assign Done_o     = (state_q == DONE);
endmodule

// File: tb/tb_multiprecision_add_seq.sv
// Scoreboard bench for multiprecision_add_seq (SEG_WIDTH=8, NUM_SEGS=4); define MULTIPRECISION_ADD_SUB_EN to exercise subtraction.

module tb_multiprecision_add_seq;
    localparam int SEG_WIDTH = 8;
    localparam int NUM_SEGS  = 4;
    localparam int W         = SEG_WIDTH * NUM_SEGS;

    logic         clk = 1'b0;
    logic         Rst_i;
    logic         Start_i;
    logic [W-1:0] Number1_i;
    logic [W-1:0] Number2_i;
    logic         Carry_i;
`ifdef MULTIPRECISION_ADD_SUB_EN
    logic         Sub_i;
`endif
    logic [W-1:0] Result_o;
    logic         Carry_o;
    logic         Overflow_o;
    logic         Busy_o;
    logic         Done_o;

    multiprecision_add_seq #(.SEG_WIDTH(SEG_WIDTH), .NUM_SEGS(NUM_SEGS)) dut (
        .Clk_i      (clk),
        .Rst_i      (Rst_i),
        .Start_i    (Start_i),
        .Number1_i  (Number1_i),
        .Number2_i  (Number2_i),
        .Carry_i    (Carry_i),
`ifdef MULTIPRECISION_ADD_SUB_EN
        .Sub_i      (Sub_i),
`endif
        .Result_o   (Result_o),
        .Carry_o    (Carry_o),
        .Overflow_o (Overflow_o),
        .Busy_o     (Busy_o),
        .Done_o     (Done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    bit   mon_en   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the whole W-bit operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        longint       sa;
        longint       sb;
        longint       s;
        logic [W:0]   full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.res = a - b;
            e.co  = (a >= b);
            s     = sa - sb;
        end else begin
            full  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.res = full[W-1:0];
            e.co  = full[W];
            s     = sa + sb + longint'(cin);
        end
        e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (Busy_o) begin
                busy_cnt++;
            end else if (Done_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL spurious_done: Done_o=1 at cycle %0d with nothing outstanding", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", Result_o, e.res);
                    chk("carry_out", W'(Carry_o), W'(e.co));
                    chk("overflow", W'(Overflow_o), W'(e.ov));
                    chk("done_cycle", W'(cyc), W'(e.due));
                    chk("busy_cycles", W'(busy_cnt), W'(NUM_SEGS));
                end
                busy_cnt = 0;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Caller is positioned at a negedge where the DUT can accept a start.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input bit expect_done);
        exp_t e;
        Start_i   = 1'b1;
        Number1_i = a;
        Number2_i = b;
        Carry_i   = cin;
`ifdef MULTIPRECISION_ADD_SUB_EN
        Sub_i     = sub;
`endif
        @(posedge clk);
        #1;
        if (expect_done) begin
            e     = model(a, b, cin, sub);
            e.due = cyc + NUM_SEGS;
            exp_q.push_back(e);
        end
        Start_i   = 1'b0;
        Number1_i = $urandom;
        Number2_i = $urandom;
        Carry_i   = 1'($urandom);
`ifdef MULTIPRECISION_ADD_SUB_EN
        Sub_i     = 1'($urandom);
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Done_o) return;
        end
        tests++;
        errors++;
        $display("FAIL done_timeout: Done_o=0 after 20 cycles, expected 1");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_result"}, Result_o, '0);
        chk({tag, "_flags"}, W'({Carry_o, Overflow_o, Busy_o, Done_o}), '0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        Rst_i     = 1'b1;
        Start_i   = 1'b0;
        Number1_i = '0;
        Number2_i = '0;
        Carry_i   = 1'b0;
`ifdef MULTIPRECISION_ADD_SUB_EN
        Sub_i     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        Rst_i  = 1'b0;
        mon_en = 1;

        // Case 1 plus hold-after-done check
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1);
        wait_done();
        repeat (2) @(negedge clk);
        chk("hold_result", Result_o, 32'h0000_0100);
        chk("idle_flags", W'({Busy_o, Done_o}), '0);

        // Case 2
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        wait_done();
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
        wait_done();

        // Case 3
        @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        wait_done();

        // Case 4: start during RUN is ignored, then back-to-back from DONE
        @(negedge clk);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1);
        repeat (2) @(negedge clk);
        Start_i   = 1'b1;
        Number1_i = 32'hFFFF_FFFF;
        Number2_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        wait_done();
        issue(32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, 1'b0, 1);
        wait_done();

        // Case 5: reset in the middle of RUN
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        Rst_i = 1'b1;
        @(posedge clk);
        #1;
        Rst_i = 1'b0;
        @(negedge clk);
        check_zero("abort");
        repeat (8) @(negedge clk);
        issue(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1);
        wait_done();

`ifdef MULTIPRECISION_ADD_SUB_EN
        // Case 6: subtraction
        @(negedge clk);
        issue(32'd5, 32'd7, 1'b1, 1'b1, 1);
        wait_done();
        @(negedge clk);
        issue(32'd7, 32'd5, 1'b0, 1'b1, 1);
        wait_done();
        @(negedge clk);
        issue(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1);
        wait_done();
`endif

        // Random traffic with gaps, back-to-back starts and ignored starts in RUN
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
`ifdef MULTIPRECISION_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            issue(ra, rb, rc, rs, 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, NUM_SEGS - 1)) @(negedge clk);
                Start_i   = 1'b1;
                Number1_i = $urandom;
                @(posedge clk);
                #1;
                Start_i = 1'b0;
            end
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
